aes_in_ctrl: RTL

- Input controller directly upstream of the AES core.
- Buffers 128-bit blocks from a valid/ready source in a small FIFO.
- Sequences key loading: pulses start, then waits for key ready.
- Issues single-cycle data_valid pulses into the core, gated by the core's ready and an in-flight limit. Holds key/mode/direction stable while any block is in flight.

---
 rtl/aes_in_ctrl_pkg.sv | 18 +
 rtl/aes_in_ctrl_if.sv | 11 +
 rtl/aes_in_ctrl_fifo.sv | 51 +++++
 rtl/aes_in_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/aes_in_ctrl_pkg.sv
// Shared constants and state encoding for the AES input controller.
package aes_pkg;
  localparam int BLOCK_W          = 128;
  localparam int KEY_W            = 256;
  localparam int KEY_BLANK_CYCLES = 2;

  localparam logic [1:0] KEY_128 = 2'd0;
  localparam logic [1:0] KEY_192 = 2'd1;
  localparam logic [1:0] KEY_256 = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    KEY_START,
    KEY_WAIT,
    RUN,
    DRAIN
  } state_t;
endpackage

// File: rtl/aes_in_ctrl_if.sv
// Valid/ready block stream feeding the AES input controller.
interface aes_in_ctrl_if;
  import aes_pkg::*;

  logic [BLOCK_W-1:0] s_data;
  logic               s_valid;
  logic               s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/aes_in_ctrl_fifo.sv
// DEPTH x 128-bit synchronous FIFO; head is valid whenever empty is low.
module aes_in_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [BLOCK_W-1:0] push_data,
  input  logic               pop,
  output logic [BLOCK_W-1:0] head,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/aes_in_ctrl.sv
// AES core input controller: block FIFO, key-load sequencing, rate/in-flight limited issue.
// Optional CBC encrypt chaining is compiled in with AES_IN_CTRL_CBC_EN.
module aes_in_ctrl
  import aes_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [KEY_W-1:0]   cfg_key,
  input  logic [1:0]         cfg_key_mode,
  input  logic               cfg_ende,
  input  logic [BLOCK_W-1:0] cfg_iv,
  output logic               cfg_busy,
  aes_in_ctrl_if.slave       src,
  output logic               aes_start,
  output logic [KEY_W-1:0]   aes_key,
  output logic [1:0]         aes_key_mode,
  output logic               aes_ende,
  output logic [BLOCK_W-1:0] aes_data,
  output logic               aes_data_valid,
  input  logic               aes_ready,
  input  logic               aes_key_ready,
  input  logic [BLOCK_W-1:0] aes_o_data,
  input  logic               aes_o_data_valid,
  output logic [3:0]         inflight
);
  localparam logic [1:0] BLANK  = 2'(KEY_BLANK_CYCLES);
  localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

  state_t             state;
  logic [1:0]         blank_cnt;
  logic [KEY_W-1:0]   sh_key;
  logic [1:0]         sh_key_mode;
  logic               sh_ende;
  logic               fifo_full;
  logic               fifo_empty;
  logic [BLOCK_W-1:0] fifo_head;
  logic               push;
  logic               issue_p0;
  logic [BLOCK_W-1:0] issue_data_p0;
  logic [3:0]         max_eff;

  // Return on an empty count is dropped rather than wrapping.
  function automatic logic [3:0] inflight_next(input logic [3:0] cur, input logic inc,
                                               input logic dec);
    if (inc && !dec) return cur + 4'd1;
    if (dec && !inc && cur != 4'd0) return cur - 4'd1;
    return cur;
  endfunction

  assign src.s_ready = reset_n && !fifo_full && (state != DRAIN);
  assign push        = src.s_valid && src.s_ready;

`ifdef AES_IN_CTRL_CBC_EN
  logic [BLOCK_W-1:0] chain;
  logic [BLOCK_W-1:0] sh_iv;
  // Encrypt chaining needs each ciphertext back before the next block can be formed.
  assign max_eff       = aes_ende ? MAX_IF : 4'd1;
  assign issue_data_p0 = aes_ende ? fifo_head : (fifo_head ^ chain);
`else
  logic unused_cbc;
  assign unused_cbc    = ^{cfg_iv, aes_o_data};
  assign max_eff       = MAX_IF;
  assign issue_data_p0 = fifo_head;
`endif

  assign issue_p0 = ((state == RUN) || (state == DRAIN)) && !fifo_empty && aes_ready &&
                    (inflight < max_eff) && !aes_data_valid;

  aes_in_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (src.s_data),
    .pop       (issue_p0),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // p0 -> p1: issue decision registered onto aes_data/aes_data_valid
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      blank_cnt      <= '0;
      cfg_busy       <= 1'b0;
      aes_start      <= 1'b0;
      aes_key        <= '0;
      aes_key_mode   <= '0;
      aes_ende       <= 1'b0;
      aes_data       <= '0;
      aes_data_valid <= 1'b0;
      inflight       <= '0;
      sh_key         <= '0;
      sh_key_mode    <= '0;
      sh_ende        <= 1'b0;
`ifdef AES_IN_CTRL_CBC_EN
      chain          <= '0;
      sh_iv          <= '0;
`endif
    end else begin
      aes_start      <= 1'b0;
      aes_data_valid <= issue_p0;
      if (issue_p0) aes_data <= issue_data_p0;
      inflight <= inflight_next(inflight, aes_data_valid, aes_o_data_valid);
`ifdef AES_IN_CTRL_CBC_EN
      if (aes_o_data_valid && !aes_ende) chain <= aes_o_data;
`endif
      case (state)
        IDLE: begin
          if (cfg_load) begin
            aes_key      <= cfg_key;
            aes_key_mode <= cfg_key_mode;
            aes_ende     <= cfg_ende;
`ifdef AES_IN_CTRL_CBC_EN
            chain        <= cfg_iv;
`endif
            aes_start    <= 1'b1;
            cfg_busy     <= 1'b1;
            state        <= KEY_START;
          end
        end
        KEY_START: begin
          blank_cnt <= '0;
          state     <= KEY_WAIT;
        end
        KEY_WAIT: begin
          // Key-ready from the previous key may still be high right after start.
          if (blank_cnt < BLANK) begin
            blank_cnt <= blank_cnt + 2'd1;
          end else if (aes_key_ready) begin
            cfg_busy <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cfg_load) begin
            sh_key      <= cfg_key;
            sh_key_mode <= cfg_key_mode;
            sh_ende     <= cfg_ende;
`ifdef AES_IN_CTRL_CBC_EN
            sh_iv       <= cfg_iv;
`endif
            cfg_busy    <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && (inflight == 4'd0) && !aes_data_valid) begin
            aes_key      <= sh_key;
            aes_key_mode <= sh_key_mode;
            aes_ende     <= sh_ende;
`ifdef AES_IN_CTRL_CBC_EN
            chain        <= sh_iv;
`endif
            aes_start    <= 1'b1;
            state        <= KEY_START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
